// File: rtl/rca_pr_request_queue_pkg.sv
// Shared types and grid-derived constants for the RCA partial-reconfiguration request queue.
package rca_pr_request_queue_pkg;

  localparam int unsigned GRID_NUM_COLS  = 4;
  localparam int unsigned GRID_NUM_ROWS  = 4;
  localparam int unsigned GRID_NUM_SLOTS = GRID_NUM_COLS * GRID_NUM_ROWS;
  localparam int unsigned PR_NUM_OUS     = 8;
  localparam int unsigned PR_SLOT_W      = $clog2(GRID_NUM_SLOTS);
  localparam int unsigned PR_OU_W        = $clog2(PR_NUM_OUS);

  typedef struct packed {
    logic [PR_SLOT_W-1:0] slot;
    logic [PR_OU_W-1:0]   ou;
  } pr_request_t;

  typedef enum logic [1:0] {
    PRQ_IDLE = 2'd0,
    PRQ_REQ  = 2'd1,
    PRQ_WAIT = 2'd2
  } pr_queue_state_t;

endpackage

// File: rtl/rca_pr_request_queue_if.sv
// Request-side and PR-controller-side handshake bundle of the PR request queue.
interface rca_pr_request_queue_if #(
  parameter int unsigned SLOT_W = 4,
  parameter int unsigned OU_W   = 3
);
  logic              req_valid;
  logic              req_ready;
  logic [SLOT_W-1:0] req_slot;
  logic [OU_W-1:0]   req_ou;
  logic              flush;
  logic              pr_valid;
  logic              pr_ready;
  logic [SLOT_W-1:0] pr_slot;
  logic [OU_W-1:0]   pr_ou;
  logic              pr_done;
  logic              pr_error;
  logic              dup_drop;

  modport slave (
    input  req_valid, req_slot, req_ou, flush, pr_ready, pr_done, pr_error,
    output req_ready, pr_valid, pr_slot, pr_ou, dup_drop
  );

  modport master (
    output req_valid, req_slot, req_ou, flush, pr_ready, pr_done, pr_error,
    input  req_ready, pr_valid, pr_slot, pr_ou, dup_drop
  );
endinterface

// File: rtl/rca_pr_slot_table.sv
// Per-slot resident-OU table: written on load completion, combinational (slot, ou) residency match.
module rca_pr_slot_table #(
  parameter int unsigned NUM_SLOTS = 16,
  parameter int unsigned NUM_OUS   = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     we,
  input  logic [$clog2(NUM_SLOTS)-1:0]             w_slot,
  input  logic [$clog2(NUM_OUS)-1:0]               w_ou,
  input  logic                                     w_loaded,
  input  logic [$clog2(NUM_SLOTS)-1:0]             m_slot,
  input  logic [$clog2(NUM_OUS)-1:0]               m_ou,
  output logic                                     hit_c,
  output logic [NUM_SLOTS-1:0]                     slot_loaded,
  output logic [NUM_SLOTS*$clog2(NUM_OUS)-1:0]     slot_ou
);

  localparam int unsigned OW = $clog2(NUM_OUS);

  logic [NUM_SLOTS-1:0] loaded_q;
  logic [OW-1:0]        ou_q [NUM_SLOTS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loaded_q <= '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) ou_q[i] <= '0;
    end else if (we) begin
      loaded_q[w_slot] <= w_loaded;
      ou_q[w_slot]     <= w_ou;
    end
  end

  assign hit_c       = loaded_q[m_slot] && (ou_q[m_slot] == m_ou);
  assign slot_loaded = loaded_q;

  for (genvar g = 0; g < int'(NUM_SLOTS); g++) begin : g_flat
    assign slot_ou[g*OW +: OW] = ou_q[g];
  end

endmodule

// File: rtl/rca_pr_request_queue.sv
// DEPTH-entry PR request queue: drops redundant requests, coalesces same-slot pending ones,
// and serialises loads to the PR controller while tracking residency per slot.
module rca_pr_request_queue
  import rca_pr_request_queue_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = GRID_NUM_SLOTS,
  parameter int unsigned NUM_OUS   = PR_NUM_OUS,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  rca_pr_request_queue_if.slave                 bus,
  output logic [$clog2(DEPTH+1)-1:0]            occupancy,
  output logic [NUM_SLOTS-1:0]                  slot_loaded,
  output logic [NUM_SLOTS*$clog2(NUM_OUS)-1:0]  slot_ou
);

  localparam int unsigned SW = $clog2(NUM_SLOTS);
  localparam int unsigned OW = $clog2(NUM_OUS);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [SW-1:0]    q_slot [DEPTH];
  logic [OW-1:0]    q_ou   [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    occ_q;
  logic [SW-1:0]    fl_slot_q;
  logic [OW-1:0]    fl_ou_q;
  logic             dup_drop_q;

  pr_queue_state_t  state_q, state_d;

  logic          full, accept, pop, push, coalesce, drop;
  logic          table_hit, flight_hit, coal_hit, table_we;
  logic [PW-1:0] coal_idx;

  assign full          = (occ_q == CW'(DEPTH));
  assign bus.req_ready = rst_n & ~full & ~bus.flush;
  assign accept        = bus.req_valid & bus.req_ready;
  assign pop           = (state_q == PRQ_IDLE) && (occ_q != '0) && !bus.flush;
  assign flight_hit    = (state_q != PRQ_IDLE) && (fl_slot_q == bus.req_slot) &&
                         (fl_ou_q == bus.req_ou);
  assign drop          = accept & (table_hit | flight_hit);
  assign coalesce      = accept & ~drop & coal_hit;
  assign push          = accept & ~drop & ~coal_hit;
  assign table_we      = (state_q == PRQ_WAIT) && bus.pr_done;

  // Same-slot pending entry; the head being popped this cycle is excluded so it leaves with its old ou.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (q_vld[i] && (q_slot[i] == bus.req_slot) && !(pop && (PW'(i) == head_q))) begin
        coal_hit = 1'b1;
        coal_idx = PW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRQ_IDLE: if (pop)          state_d = PRQ_REQ;
      PRQ_REQ:  if (bus.pr_ready) state_d = PRQ_WAIT;
      PRQ_WAIT: if (bus.pr_done)  state_d = PRQ_IDLE;
      default:                    state_d = PRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= PRQ_IDLE;
      q_vld      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      fl_slot_q  <= '0;
      fl_ou_q    <= '0;
      dup_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dup_drop_q <= drop;
      if (pop) begin
        fl_slot_q <= q_slot[head_q];
        fl_ou_q   <= q_ou[head_q];
      end
      if (bus.flush) begin
        q_vld  <= '0;
        head_q <= '0;
        tail_q <= '0;
        occ_q  <= '0;
      end else begin
        if (pop) begin
          q_vld[head_q] <= 1'b0;
          head_q        <= head_q + PW'(1);
        end
        if (push) begin
          q_vld[tail_q] <= 1'b1;
          tail_q        <= tail_q + PW'(1);
        end
        occ_q <= occ_q + CW'(push) - CW'(pop);
      end
    end
  end

  // Entry payload needs no reset: it is only read where its valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      q_slot[tail_q] <= bus.req_slot;
      q_ou[tail_q]   <= bus.req_ou;
    end
    if (coalesce) q_ou[coal_idx] <= bus.req_ou;
  end

  rca_pr_slot_table #(
    .NUM_SLOTS (NUM_SLOTS),
    .NUM_OUS   (NUM_OUS)
  ) u_slot_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (table_we),
    .w_slot      (fl_slot_q),
    .w_ou        (fl_ou_q),
    .w_loaded    (~bus.pr_error),
    .m_slot      (bus.req_slot),
    .m_ou        (bus.req_ou),
    .hit_c       (table_hit),
    .slot_loaded (slot_loaded),
    .slot_ou     (slot_ou)
  );

  assign bus.pr_valid = (state_q == PRQ_REQ);
  assign bus.pr_slot  = fl_slot_q;
  assign bus.pr_ou    = fl_ou_q;
  assign bus.dup_drop = dup_drop_q;
  assign occupancy    = occ_q;

endmodule
